bcd7_scan_ctrl: RTL and testbench

- Time-multiplexes one BCD-to-7-segment decoder across DIGITS common-anode digit positions.
- Sequences the decoder's 4-bit code input and drives active-low digit enables.
- Inserts a dead-time blank between digits to prevent ghosting.
- Double-buffers the displayed value so a frame never shows a mix of old and new digits.

---
 rtl/bcd7_scan_ctrl_if.sv | 15 +
 rtl/bcd7_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_bcd7_scan_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bcd7_scan_ctrl_if.sv
// Display-side bundle for bcd7_scan_ctrl: control/value inputs and the
// multiplexed decoder code, digit enables and frame strobe.
interface bcd7_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [3:0]            q;
  logic [DIGITS-1:0]     dig_n;
  logic                  frame_done;

  modport master (output enable, load, bcd_in, input q, dig_n, frame_done);
  modport slave  (input enable, load, bcd_in, output q, dig_n, frame_done);
endinterface

// File: rtl/bcd7_scan_ctrl.sv
// Time-multiplexed BCD 7-seg scanner with dead-time blanking and a
// double-buffered value. Define BCD7_SCAN_LZ_BLANK_EN for leading-zero blanking.
module bcd7_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SHOW_CYC  = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  bcd7_scan_ctrl_if.slave   scan
);
  localparam int MAXC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int IW   = $clog2(DIGITS);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic [IW-1:0]            idx, idx_nxt;
  logic [DIGITS-1:0][3:0]   shadow, active, active_nxt;
  logic [3:0]               q_r, q_nxt;
  logic [DIGITS-1:0]        dig_n_r, dig_n_nxt;
  logic                     fd_r, fd_nxt;
  logic [DIGITS-1:0]        lit;

  // Per-digit "may light" mask, derived only from the latched frame value.
`ifdef BCD7_SCAN_LZ_BLANK_EN
  logic [DIGITS:0] hi_zero;
  assign hi_zero[DIGITS] = 1'b1;
`endif
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
`ifdef BCD7_SCAN_LZ_BLANK_EN
    assign hi_zero[k] = hi_zero[k+1] && (active[k] == 4'd0);
    if (k == 0) begin : g_lsd
      assign lit[k] = (active[k] <= 4'd9);
    end else begin : g_hsd
      assign lit[k] = (active[k] <= 4'd9) && !hi_zero[k];
    end
`else
    assign lit[k] = (active[k] <= 4'd9);
`endif
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CW'(1);
    idx_nxt    = idx;
    active_nxt = active;
    q_nxt      = q_r;
    dig_n_nxt  = dig_n_r;
    fd_nxt     = 1'b0;
    if (!scan.enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      dig_n_nxt = '1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt  = BLANK;
          cnt_nxt    = '0;
          idx_nxt    = '0;
          active_nxt = shadow;
          q_nxt      = shadow[0];
          dig_n_nxt  = '1;
        end
        BLANK: begin
          if (cnt == CW'(BLANK_CYC - 1)) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
            dig_n_nxt = lit[idx] ? ~(DIGITS'(1) << idx) : '1;
          end
        end
        SHOW: begin
          if (cnt == CW'(SHOW_CYC - 1)) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            dig_n_nxt = '1;
            // Frame boundary: shadow is sampled before any same-edge load lands.
            if (idx == IW'(DIGITS - 1)) begin
              idx_nxt    = '0;
              active_nxt = shadow;
              q_nxt      = shadow[0];
              fd_nxt     = 1'b1;
            end else begin
              idx_nxt = idx + IW'(1);
              q_nxt   = active[idx + IW'(1)];
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          dig_n_nxt = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shadow  <= '0;
      active  <= '0;
      q_r     <= '0;
      dig_n_r <= '1;
      fd_r    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      active  <= active_nxt;
      q_r     <= q_nxt;
      dig_n_r <= dig_n_nxt;
      fd_r    <= fd_nxt;
      if (scan.load) shadow <= scan.bcd_in;
    end
  end

  assign scan.q          = q_r;
  assign scan.dig_n      = dig_n_r;
  assign scan.frame_done = fd_r;
endmodule

// File: tb/tb_bcd7_scan_ctrl.sv
// Directed bench for bcd7_scan_ctrl (DIGITS=4, SHOW_CYC=4, BLANK_CYC=2).
module tb_bcd7_scan_ctrl;
  localparam int SHOW  = 4;
  localparam int BLANK = 2;
  localparam int PER   = SHOW + BLANK;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  lit;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  bcd7_scan_ctrl_if #(.DIGITS(4)) bus ();

  bcd7_scan_ctrl #(.DIGITS(4), .SHOW_CYC(SHOW), .BLANK_CYC(BLANK)) dut (
    .clk  (clk),
    .rst  (rst),
    .scan (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Checks one whole frame from its first BLANK cycle; optionally pulses
  // load at frame-cycle load_at (sampled on the following rising edge).
  task automatic check_frame(input logic [15:0] val, input logic [3:0] lit,
                             input bit fd_first, input int load_at,
                             input logic [15:0] ld_val);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < PER; c++) begin
        logic [3:0] exp_dn;
        logic [3:0] nib;
        @(negedge clk);
        nib    = val[d*4 +: 4];
        exp_dn = 4'b1111;
        if (c >= BLANK && lit[d]) exp_dn[d] = 1'b0;
        chk($sformatf("dig_n v=%h d%0d c%0d", val, d, c), {12'd0, bus.dig_n}, {12'd0, exp_dn});
        chk($sformatf("q v=%h d%0d c%0d", val, d, c), {12'd0, bus.q}, {12'd0, nib});
        chk($sformatf("frame_done v=%h d%0d c%0d", val, d, c), {15'd0, bus.frame_done},
            {15'd0, (fd_first && d == 0 && c == 0)});
        bus.load = 1'b0;
        if (d*PER + c == load_at) begin
          bus.load   = 1'b1;
          bus.bcd_in = ld_val;
        end
      end
    end
  endtask

  // Called on a falling edge: drop enable, load value, check idle, restart.
  task automatic start_run(input logic [15:0] val);
    bus.enable = 1'b0;
    bus.load   = 1'b1;
    bus.bcd_in = val;
    @(negedge clk);
    chk("idle dig_n", {12'd0, bus.dig_n}, 16'h000f);
    chk("idle frame_done", {15'd0, bus.frame_done}, 16'h0000);
    bus.load   = 1'b0;
    bus.enable = 1'b1;
  endtask

  vec_t vecs[8];
  logic [3:0] lit0;

  initial begin
`ifdef BCD7_SCAN_LZ_BLANK_EN
    vecs[0] = '{16'h1234, 4'b1111};
    vecs[1] = '{16'h12A4, 4'b1101};
    vecs[2] = '{16'h0042, 4'b0011};
    vecs[3] = '{16'h0000, 4'b0001};
    vecs[4] = '{16'h1000, 4'b1111};
    vecs[5] = '{16'h0F00, 4'b0011};
    vecs[6] = '{16'hA000, 4'b0111};
    vecs[7] = '{16'h9999, 4'b1111};
    lit0    = 4'b0001;
`else
    vecs[0] = '{16'h1234, 4'b1111};
    vecs[1] = '{16'h12A4, 4'b1101};
    vecs[2] = '{16'h0042, 4'b1111};
    vecs[3] = '{16'h0000, 4'b1111};
    vecs[4] = '{16'h1000, 4'b1111};
    vecs[5] = '{16'h0F00, 4'b1011};
    vecs[6] = '{16'hA000, 4'b0111};
    vecs[7] = '{16'h9999, 4'b1111};
    lit0    = 4'b1111;
`endif
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    bus.bcd_in = '0;

    // Reset state, then a long disabled stretch.
    @(negedge clk);
    @(negedge clk);
    chk("rst dig_n", {12'd0, bus.dig_n}, 16'h000f);
    chk("rst q", {12'd0, bus.q}, 16'h0000);
    chk("rst frame_done", {15'd0, bus.frame_done}, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk($sformatf("disabled dig_n c%0d", i), {11'd0, bus.frame_done, bus.dig_n}, 16'h000f);
    end

    // Table: two frames per value, the second checks the frame_done period.
    foreach (vecs[i]) begin
      start_run(vecs[i].val);
      check_frame(vecs[i].val, vecs[i].lit, 1'b0, -1, '0);
      check_frame(vecs[i].val, vecs[i].lit, 1'b1, -1, '0);
    end

    // Double buffering: load mid-frame during digit 1 SHOW.
    start_run(16'h1234);
    check_frame(16'h1234, 4'b1111, 1'b0, PER + BLANK + 1, 16'h5678);
    check_frame(16'h5678, 4'b1111, 1'b1, -1, '0);

    // Load on the very edge that copies shadow->active and raises frame_done.
    check_frame(16'h5678, 4'b1111, 1'b1, 4*PER - 1, 16'h9999);
    check_frame(16'h5678, 4'b1111, 1'b1, -1, '0);
    check_frame(16'h9999, 4'b1111, 1'b1, -1, '0);

    // Enable dropped in digit 1 SHOW, then re-enabled.
    start_run(16'h1234);
    for (int i = 0; i <= PER + BLANK; i++) @(negedge clk);
    chk("pre-drop dig_n", {12'd0, bus.dig_n}, 16'h000d);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("drop dig_n", {12'd0, bus.dig_n}, 16'h000f);
    chk("drop frame_done", {15'd0, bus.frame_done}, 16'h0000);
    bus.enable = 1'b1;
    check_frame(16'h1234, 4'b1111, 1'b0, -1, '0);

    // Asynchronous reset during digit 2 SHOW; shadow returns to zero.
    start_run(16'h1234);
    for (int i = 0; i <= 2*PER + BLANK; i++) @(negedge clk);
    chk("pre-rst dig_n", {12'd0, bus.dig_n}, 16'h000b);
    rst = 1'b1;
    #1;
    chk("async rst dig_n", {12'd0, bus.dig_n}, 16'h000f);
    chk("async rst q", {12'd0, bus.q}, 16'h0000);
    chk("async rst frame_done", {15'd0, bus.frame_done}, 16'h0000);
    @(negedge clk);
    chk("held rst outputs", {11'd0, bus.frame_done, bus.dig_n}, 16'h000f);
    rst = 1'b0;
    check_frame(16'h0000, lit0, 1'b0, -1, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
